// File: rtl/comparador_serial_d_i_pkg.sv
// Shared constants for the serial comparator: result codes, FSM state encodings
// and the typical (non-MSB) bit-cell rule.
package comparador_serial_d_i_pkg;

    typedef logic [1:0] resultado_t;
    typedef logic [1:0] estado_t;

    // Result codes double as the carry encoding between bit cells
    localparam resultado_t RES_IGUAL = 2'b00;
    localparam resultado_t RES_MAYOR = 2'b01;
    localparam resultado_t RES_MENOR = 2'b10;

    localparam estado_t REPOSO  = 2'd0;
    localparam estado_t COMPARA = 2'd1;
    localparam estado_t LISTO   = 2'd2;

    // A differing bit pair overrides any verdict from lower bits
    function automatic resultado_t reglaTipica(
        input logic       a,
        input logic       b,
        input resultado_t carry
    );
        if (a != b) begin
            return a ? RES_MAYOR : RES_MENOR;
        end
        return carry;
    endfunction

endpackage

// File: rtl/celda_d_i.sv
// One bit step of the LSB-first comparator. With COMPARADOR_SIGNO_EN defined the
// final (MSB) cell treats the bits as two's-complement sign bits.
module celda_d_i
    import comparador_serial_d_i_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic [1:0] carryIn,
    input  logic       es_final,
    output logic [1:0] carryOut
);

    always_comb begin
        carryOut = reglaTipica(a_i, b_i, carryIn);
`ifdef COMPARADOR_SIGNO_EN
        // A set sign bit means the more negative operand
        if (es_final && (a_i != b_i)) begin
            carryOut = a_i ? RES_MENOR : RES_MAYOR;
        end
`endif
    end

`ifndef COMPARADOR_SIGNO_EN
    logic unusedFinal;
    assign unusedFinal = es_final;
`endif

endmodule

// File: rtl/comparador_serial_d_i.sv
// Bit-serial magnitude comparator with valid/ready handshakes on both sides.
// Signed comparison is selected at build time by COMPARADOR_SIGNO_EN.
module comparador_serial_d_i
    import comparador_serial_d_i_pkg::*;
#(
    parameter int unsigned ANCHO = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] palabraA,
    input  logic [ANCHO-1:0] palabraB,
    input  logic             entrada_valida,
    output logic             entrada_lista,
    output logic [1:0]       resultado,
    output logic             salida_valida,
    input  logic             salida_lista
);

    localparam int unsigned CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    estado_t          estadoQ, estadoD;
    logic [ANCHO-1:0] regAQ, regAD;
    logic [ANCHO-1:0] regBQ, regBD;
    logic [CW-1:0]    contadorQ, contadorD;
    resultado_t       acarreoQ, acarreoD;

    logic       esFinal;
    resultado_t acarreoCelda;

    assign esFinal = (contadorQ == ULTIMO);

    // Shift registers present the current bit at position 0
    celda_d_i uCelda (
        .a_i      (regAQ[0]),
        .b_i      (regBQ[0]),
        .carryIn  (acarreoQ),
        .es_final (esFinal),
        .carryOut (acarreoCelda)
    );

    always_comb begin
        estadoD   = estadoQ;
        regAD     = regAQ;
        regBD     = regBQ;
        contadorD = contadorQ;
        acarreoD  = acarreoQ;
        case (estadoQ)
            REPOSO: begin
                if (entrada_valida) begin
                    regAD     = palabraA;
                    regBD     = palabraB;
                    contadorD = '0;
                    acarreoD  = RES_IGUAL;
                    estadoD   = COMPARA;
                end
            end
            COMPARA: begin
                acarreoD = acarreoCelda;
                regAD    = {1'b0, regAQ[ANCHO-1:1]};
                regBD    = {1'b0, regBQ[ANCHO-1:1]};
                if (esFinal) begin
                    estadoD = LISTO;
                end else begin
                    contadorD = contadorQ + CW'(1);
                end
            end
            LISTO: begin
                if (salida_lista) begin
                    estadoD = REPOSO;
                end
            end
            default: estadoD = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estadoQ   <= REPOSO;
            regAQ     <= '0;
            regBQ     <= '0;
            contadorQ <= '0;
            acarreoQ  <= RES_IGUAL;
        end else begin
            estadoQ   <= estadoD;
            regAQ     <= regAD;
            regBQ     <= regBD;
            contadorQ <= contadorD;
            acarreoQ  <= acarreoD;
        end
    end

    // Outputs decode straight from state so reset clears them without an edge
    always_comb begin
        entrada_lista = (estadoQ == REPOSO);
        salida_valida = (estadoQ == LISTO);
        resultado     = (estadoQ == LISTO) ? acarreoQ : RES_IGUAL;
    end

endmodule

// File: tb/tb_comparador_serial_d_i.sv
// Self-checking bench for comparador_serial_d_i (ANCHO=3): vector table plus
// backpressure, operand-change and mid-comparison reset sequences.
module tb_comparador_serial_d_i;

    localparam int unsigned ANCHO = 3;

    logic             clk;
    logic             rst_n;
    logic [ANCHO-1:0] palabraA;
    logic [ANCHO-1:0] palabraB;
    logic             entrada_valida;
    logic             entrada_lista;
    logic [1:0]       resultado;
    logic             salida_valida;
    logic             salida_lista;

    comparador_serial_d_i #(.ANCHO(ANCHO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .palabraA       (palabraA),
        .palabraB       (palabraB),
        .entrada_valida (entrada_valida),
        .entrada_lista  (entrada_lista),
        .resultado      (resultado),
        .salida_valida  (salida_valida),
        .salida_lista   (salida_lista)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] expU;
        logic [1:0] expS;
    } vec_t;

    vec_t       tabla [12];
    logic [1:0] sbq   [$];
    int         nVec;
    int         nFail;

    function automatic logic [1:0] elige(input logic [1:0] u, input logic [1:0] s);
`ifdef COMPARADOR_SIGNO_EN
        return s;
`else
        return u;
`endif
    endfunction

    task automatic check(input string nombre, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", nombre, act, exp);
        end
    endtask

    // Full transaction; operands are scrambled right after the handshake
    task automatic runVector(input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] a2, input logic [2:0] b2,
                             input logic [1:0] expRes, input int hold);
        int espera;
        int edges;
        logic [1:0] esperado;
        logic [1:0] visto;
        espera = 0;
        while (!entrada_lista && espera < 20) begin
            @(negedge clk);
            espera++;
        end
        check("entrada_lista_before_start", int'(entrada_lista), 1);
        palabraA       = a;
        palabraB       = b;
        entrada_valida = 1'b1;
        salida_lista   = (hold == 0);
        @(negedge clk);
        sbq.push_back(expRes);
        entrada_valida = 1'b0;
        palabraA       = a2;
        palabraB       = b2;
        check("entrada_lista_in_compara", int'(entrada_lista), 0);
        edges = 1;
        while (!salida_valida && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("latency_edges", edges, ANCHO + 1);
        esperado = sbq.pop_front();
        check("resultado", int'(resultado), int'(esperado));
        visto = resultado;
        for (int i = 0; i < hold; i++) begin
            entrada_valida = 1'b1;
            palabraA       = 3'(i);
            palabraB       = 3'(7 - i);
            @(negedge clk);
            check("hold_salida_valida", int'(salida_valida), 1);
            check("hold_resultado", int'(resultado), int'(visto));
            check("hold_entrada_lista", int'(entrada_lista), 0);
        end
        entrada_valida = 1'b0;
        salida_lista   = 1'b1;
        @(negedge clk);
        check("back_to_reposo", int'(entrada_lista), 1);
        check("idle_salida_valida", int'(salida_valida), 0);
        check("idle_resultado", int'(resultado), 0);
    endtask

    initial begin
        nVec  = 0;
        nFail = 0;
        //            a     b     unsigned  signed
        tabla[0]  = '{3'd5, 3'd3, 2'b01, 2'b10};
        tabla[1]  = '{3'd6, 3'd6, 2'b00, 2'b00};
        tabla[2]  = '{3'd2, 3'd6, 2'b10, 2'b01};
        tabla[3]  = '{3'd4, 3'd3, 2'b01, 2'b10};
        tabla[4]  = '{3'd0, 3'd0, 2'b00, 2'b00};
        tabla[5]  = '{3'd7, 3'd0, 2'b01, 2'b10};
        tabla[6]  = '{3'd0, 3'd7, 2'b10, 2'b01};
        tabla[7]  = '{3'd1, 3'd2, 2'b10, 2'b10};
        tabla[8]  = '{3'd3, 3'd1, 2'b01, 2'b01};
        tabla[9]  = '{3'd6, 3'd5, 2'b01, 2'b01};
        tabla[10] = '{3'd7, 3'd4, 2'b01, 2'b01};
        tabla[11] = '{3'd4, 3'd5, 2'b10, 2'b10};

        palabraA       = '0;
        palabraB       = '0;
        entrada_valida = 1'b0;
        salida_lista   = 1'b1;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_entrada_lista", int'(entrada_lista), 1);
        check("reset_salida_valida", int'(salida_valida), 0);
        check("reset_resultado", int'(resultado), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            runVector(tabla[i].a, tabla[i].b, 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), elige(tabla[i].expU, tabla[i].expS), 0);
        end

        // Backpressure for five cycles
        runVector(3'd5, 3'd3, 3'd0, 3'd0, elige(2'b01, 2'b10), 5);
        // Operands change mid-comparison
        runVector(3'd1, 3'd0, 3'd0, 3'd7, 2'b01, 0);

        // Reset during the second COMPARA cycle
        palabraA       = 3'd6;
        palabraB       = 3'd1;
        entrada_valida = 1'b1;
        @(negedge clk);
        sbq.push_back(2'b01);
        entrada_valida = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_entrada_lista", int'(entrada_lista), 1);
        check("midreset_salida_valida", int'(salida_valida), 0);
        check("midreset_resultado", int'(resultado), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_no_valid", int'(salida_valida), 0);
        end
        runVector(3'd3, 3'd4, 3'd7, 3'd0, elige(2'b10, 2'b01), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/comparador_serial_d_i.md
COMPARADOR_SERIAL_D_I -- requirements
Module: comparador_serial_d_i

Interface
REQ-001 Parameter ANCHO, default 3: word width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 palabraA  input  ANCHO  operand A, sampled on an input handshake.
REQ-005 palabraB  input  ANCHO  operand B, sampled on an input handshake.
REQ-006 entrada_valida  input  1  operands on palabraA/palabraB are valid.
REQ-007 entrada_lista  output  1  block can accept operands.
REQ-008 resultado  output  2  comparison code: 00 = A==B, 01 = A>B, 10 = A<B; 11 is never driven.
REQ-009 salida_valida  output  1  resultado is valid.
REQ-010 salida_lista  input  1  downstream accepts resultado.

Function
REQ-011 The FSM SHALL have exactly three states: REPOSO, COMPARA and LISTO.
REQ-012 entrada_lista SHALL equal 1 only in REPOSO.
REQ-013 An input handshake occurs when entrada_valida and entrada_lista are both 1 on a rising edge. On that edge the block SHALL:
- latch both operands into internal shift registers;
- clear the bit counter to 0;
- set the carry to EQ (initial cell);
- go to COMPARA.
REQ-014 In COMPARA, each cycle SHALL process one bit pair, LSB first (right to left), at the index given by the counter.
REQ-015 Typical cell rule: if a_i != b_i, carry becomes GT when a_i=1 and LT when a_i=0; otherwise carry is unchanged.
REQ-016 The MSB step (counter = ANCHO-1) SHALL use the final-cell rule (see REQ-027). After it the FSM SHALL go to LISTO.
REQ-017 COMPARA SHALL last exactly ANCHO cycles. salida_valida SHALL rise on the edge that ends the last COMPARA cycle, so latency from the input handshake to salida_valida is ANCHO+1 edges.
REQ-018 In LISTO:
- salida_valida SHALL be 1;
- resultado SHALL hold the final carry;
- both outputs SHALL stay stable while salida_lista=0.
REQ-019 An output handshake (salida_valida and salida_lista both 1 on an edge) SHALL return the FSM to REPOSO. A new input can be accepted no earlier than the following edge.
REQ-020 Outside LISTO, salida_valida SHALL be 0 and resultado SHALL be 00.
REQ-021 entrada_valida while not in REPOSO SHALL be ignored; operands SHALL NOT change mid-comparison.
REQ-022 salida_lista while not in LISTO SHALL be ignored.
REQ-023 The counter SHALL be ceil(log2(ANCHO)) bits wide, SHALL NOT wrap within one comparison, and SHALL be reset to 0 on each input handshake.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state REPOSO;
- entrada_lista=1;
- salida_valida=0;
- resultado=00;
- counter 0 and carry EQ.
REQ-025 Reset in COMPARA or LISTO SHALL abort the comparison with no output handshake. The first handshake after deassertion SHALL start a clean comparison.
REQ-026 Deassertion SHALL take effect on the first rising edge of clk at which rst_n is 1.

Configuration
REQ-027 Macro COMPARADOR_SIGNO_EN selects the comparison type:
- Defined: operands are two's complement. In the MSB step, if a_msb != b_msb, carry becomes LT when a_msb=1 and GT when a_msb=0; otherwise the typical rule applies.
- Undefined: operands are unsigned, and the MSB step uses the typical rule.

Structure
REQ-028 A shared package SHALL hold:
- result codes RES_IGUAL=00, RES_MAYOR=01, RES_MENOR=10;
- the state enumeration (REPOSO, COMPARA, LISTO).
REQ-029 One combinational sub-module, celda_d_i, SHALL implement one bit step.
- Inputs: a_i, b_i, carry in, es_final.
- Output: carry out.
- The signed rule applies when es_final=1 and COMPARADOR_SIGNO_EN is defined.
REQ-030 The top level SHALL contain only the FSM, counter, shift registers, carry register and handshake logic.

Verification
REQ-031 All scenarios use ANCHO=3 with salida_lista=1 unless stated.
- Scenario 1: A=5, B=3 -> resultado=01, salida_valida first high 4 edges after the handshake.
- Scenario 2: A=6, B=6 -> resultado=00; A=2, B=6 -> resultado=10.
- Scenario 3 (sign macro): A=100b, B=011b. Macro defined -> 10; macro undefined -> 01.
- Scenario 4 (backpressure): salida_lista=0 for 5 cycles after salida_valida rises.
  - Required: resultado and salida_valida stay stable; new entrada_valida pulses are ignored.
  - Required: after salida_lista=1, REPOSO and entrada_lista=1 on the next edge.
- Scenario 5 (operand change mid-comparison): A=1, B=0 accepted, then the operand inputs change to A=0, B=7 during COMPARA -> resultado=01.
- Scenario 6 (reset mid-operation): rst_n pulsed low during the second COMPARA cycle.
  - Required: outputs go to reset values immediately, with no salida_valida.
  - Required: a following A=3, B=4 -> resultado=10.
